// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1) with a DEPTH-entry receive FIFO, RTS flow control and sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and the rx_parity_err output.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ   = 12_000_000,
  parameter int unsigned BIT_RATE = 93_750,
  parameter int unsigned DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic       uart_rts,
  input  logic       rx_read,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_overrun,
  output logic       rx_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       rx_parity_err,
`endif
  input  logic       clr_err
);

  localparam int unsigned CyclesPerBit = CLK_HZ / BIT_RATE;
  localparam int unsigned CntW         = $clog2(CyclesPerBit);
  localparam int unsigned PtrW         = $clog2(DEPTH);
  localparam int unsigned CountW       = PtrW + 1;

  localparam logic [CntW-1:0]   HalfLoad = CntW'(CyclesPerBit / 2 - 1);
  localparam logic [CntW-1:0]   FullLoad = CntW'(CyclesPerBit - 1);
  localparam logic [CountW-1:0] DepthC   = CountW'(DEPTH);
  localparam logic [CountW-1:0] RtsLevel = CountW'(DEPTH - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  logic [1:0]        sync_q;
  logic              rxd_s;
  state_e            state_q, state_d;
  logic [CntW-1:0]   timer_q, timer_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              expired;
  logic              push_req;
  logic              frame_set;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              par_set;
  logic              parity_err_q;
`endif

  logic [7:0]        mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              pop, full, push_ok, overrun_set;
  logic [7:0]        head_d;
  logic              rx_valid_q, rts_q, overrun_q, frame_err_q;
  logic [7:0]        rx_data_q;

  assign rxd_s   = sync_q[1];
  assign expired = (timer_q == '0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rxd_s) begin
          timer_d = HalfLoad;
          state_d = StStart;
        end
      end
      StStart: begin
        if (!expired) begin
          timer_d = timer_q - CntW'(1);
        end else if (!rxd_s) begin
          timer_d   = FullLoad;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (!expired) begin
          timer_d = timer_q - CntW'(1);
        end else begin
          shift_d   = {rxd_s, shift_q[7:1]};
          timer_d   = FullLoad;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (!expired) begin
          timer_d = timer_q - CntW'(1);
        end else begin
          // Even parity: data ones plus parity bit must be even.
          par_bad_d = (^shift_q) ^ rxd_s;
          timer_d   = FullLoad;
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (!expired) begin
          timer_d = timer_q - CntW'(1);
        end else begin
          // Back to idle on the sample itself so an adjacent start bit is not missed.
          state_d = StIdle;
`ifdef UART_RX_PARITY_EN
          par_set  = par_bad_q;
          push_req = rxd_s && !par_bad_q;
`else
          push_req = rxd_s;
`endif
          frame_set = !rxd_s;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop         = rx_read && (count_q != '0);
    full        = (count_q == DepthC);
    push_ok     = push_req && (!full || pop);
    overrun_set = push_req && full && !pop;
    wr_ptr_d    = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d     = count_q + CountW'(push_ok) - CountW'(pop);
    // The incoming byte becomes the head when it lands in the slot the read pointer moves to.
    head_d      = (push_ok && (wr_ptr_q == rd_ptr_d)) ? shift_q : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= 2'b11;
      state_q      <= StIdle;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      rts_q        <= 1'b1;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[0], uart_rxd};
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rx_valid_q  <= (count_d != '0);
      if (count_d != '0) begin
        rx_data_q <= head_d;
      end
      rts_q       <= (count_q >= RtsLevel);
      // Set beats clear when both happen in the same cycle.
      overrun_q   <= overrun_set || (overrun_q && !clr_err);
      frame_err_q <= frame_set || (frame_err_q && !clr_err);
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= par_set || (parity_err_q && !clr_err);
`endif
    end
  end

  assign uart_rts     = rts_q;
  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames drive a queue-based model, a monitor checks pops.
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 12_000_000 / 93_750;
  localparam int unsigned DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Clock edges from the edge before the start bit to the stop-bit sample.
  localparam int STOP_OFS = 3 + CPB / 2 + (NBITS - 1) * CPB;

  logic       clk, rst, uart_rxd, uart_rts, rx_read, rx_valid, rx_overrun, rx_frame_err, clr_err;
  logic [7:0] rx_data;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  uart_rx_fifo #(.CLK_HZ(12_000_000), .BIT_RATE(93_750), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rxd     (uart_rxd),
    .uart_rts     (uart_rts),
    .rx_read      (rx_read),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .clr_err      (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: received bytes in order, plus sticky flags.
  logic [7:0] model_q[$];
  logic [8:0] exp_read[$];
  bit         m_overrun, m_frame;
  int         n_cmp, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the CPU reads, compare what the DUT presents with the expected pop.
  always @(negedge clk) begin
    if (rx_read) begin
      if (exp_read.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL read_sb: got read with no expected entry at %0t", $time);
      end else begin
        logic [8:0] e;
        e = exp_read.pop_front();
        chk("read_data", {23'd0, rx_valid, rx_valid ? rx_data : 8'h00}, {23'd0, e});
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int abort_at);
    logic [10:0] fr;
`ifdef UART_RX_PARITY_EN
    fr = {stop_ok, ^b, b, 1'b0};
`else
    fr = {1'b0, stop_ok, b, 1'b0};
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < NBITS - 1; i++) begin
      uart_rxd = fr[i];
      if (i == abort_at) begin
        repeat (CPB / 2) @(posedge clk);
        return;
      end
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rxd = fr[NBITS-1];
    repeat (2 + CPB / 2) @(posedge clk);
    @(negedge clk);
    chk("valid_before_stop", {31'd0, rx_valid}, {31'd0, model_q.size() != 0});
    @(posedge clk);
    if (!stop_ok) m_frame = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else m_overrun = 1'b1;
    @(negedge clk);
    chk("valid_after_stop", {31'd0, rx_valid}, {31'd0, model_q.size() != 0});
    if (model_q.size() != 0) chk("head_after_stop", {24'd0, rx_data}, {24'd0, model_q[0]});
    repeat (CPB / 2 - 3) @(posedge clk);
    #1;
    uart_rxd = 1'b1;
    if (!stop_ok) repeat (CPB) @(posedge clk);
  endtask

  task automatic do_read();
    @(posedge clk);
    #1;
    if (model_q.size() > 0) exp_read.push_back({1'b1, model_q.pop_front()});
    else exp_read.push_back(9'h000);
    rx_read = 1'b1;
    @(posedge clk);
    #1;
    rx_read = 1'b0;
  endtask

  task automatic do_clr();
    @(posedge clk);
    #1;
    clr_err   = 1'b1;
    m_overrun = 1'b0;
    m_frame   = 1'b0;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  task automatic check_state(input string pfx);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({pfx, "_valid"}, {31'd0, rx_valid}, {31'd0, model_q.size() != 0});
    chk({pfx, "_rts"}, {31'd0, uart_rts}, {31'd0, model_q.size() >= DEPTH - 1});
    chk({pfx, "_overrun"}, {31'd0, rx_overrun}, {31'd0, m_overrun});
    chk({pfx, "_frame"}, {31'd0, rx_frame_err}, {31'd0, m_frame});
    if (model_q.size() != 0) chk({pfx, "_head"}, {24'd0, rx_data}, {24'd0, model_q[0]});
`ifdef UART_RX_PARITY_EN
    chk({pfx, "_parity"}, {31'd0, rx_parity_err}, 32'd0);
`endif
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    n_cmp = 0; n_err = 0; m_overrun = 0; m_frame = 0;
    rst = 1'b1; uart_rxd = 1'b1; rx_read = 1'b0; clr_err = 1'b0;
    #23;
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_rts", {31'd0, uart_rts}, 32'd1);
    chk("rst_overrun", {31'd0, rx_overrun}, 32'd0);
    chk("rst_frame", {31'd0, rx_frame_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Single byte, then pop.
    send_frame(8'hA5, 1'b1, -1);
    check_state("t1");
    do_read();
    @(negedge clk);
    chk("t1_valid_after_pop", {31'd0, rx_valid}, {31'd0, model_q.size() != 0});
    check_state("t1_pop");

    // Three bytes raise RTS; reads drain in order.
    send_frame(8'h01, 1'b1, -1);
    send_frame(8'h02, 1'b1, -1);
    send_frame(8'h03, 1'b1, -1);
    check_state("t2_full3");
    do_read();
    check_state("t2_read1");
    do_read();
    do_read();
    check_state("t2_empty");

    // Overrun on the fifth byte.
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1, -1);
    check_state("t3_overrun");
    do_clr();
    check_state("t3_clr");
    for (int i = 0; i < DEPTH; i++) do_read();
    check_state("t3_drain");

    // Framing error, then a short glitch on the idle line.
    send_frame(8'h55, 1'b0, -1);
    check_state("t4_frame");
    @(posedge clk);
    #1;
    uart_rxd = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    uart_rxd = 1'b1;
    repeat (300) @(posedge clk);
    check_state("t4_glitch");
    do_clr();
    check_state("t4_clr");

    // Full FIFO with a pop coinciding with the stop sample of the fifth byte.
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, -1);
    b = 8'($urandom);
    fork
      send_frame(b, 1'b1, -1);
      begin
        @(posedge clk);
        repeat (STOP_OFS - 2) @(posedge clk);
        do_read();
      end
    join
    check_state("t5_same_cycle");
    for (int i = 0; i < DEPTH; i++) do_read();
    check_state("t5_drain");

    // Reset mid-frame.
    send_frame(8'h77, 1'b1, -1);
    check_state("t6_pre");
    send_frame(8'hC3, 1'b1, 5);
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    m_overrun = 0;
    m_frame   = 0;
    chk("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("t6_rst_data", {24'd0, rx_data}, 32'd0);
    chk("t6_rst_rts", {31'd0, uart_rts}, 32'd1);
    uart_rxd = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    send_frame(8'h3C, 1'b1, -1);
    check_state("t6_after");
    do_read();
    check_state("t6_read");

    // Randomized traffic.
    for (int n = 0; n < 20; n++) begin
      int nreads;
      send_frame(8'($urandom), $urandom_range(0, 5) != 0, -1);
      if ($urandom_range(0, 3) == 0) do_clr();
      nreads = $urandom_range(0, 2);
      for (int r = 0; r < nreads; r++) do_read();
      check_state("rnd");
    end
    for (int i = 0; i < DEPTH; i++) do_read();
    check_state("final");

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver with an integrated receive FIFO and RTS flow control.
- Sits between the board-level UART RX pin and the CPU's memory-mapped UART data/status registers.
- CPU reads bytes via a pop strobe. Overrun and framing errors are reported as sticky flags.

Parameters:
CLK_HZ, 12_000_000, system clock frequency in Hz
BIT_RATE, 93_750, UART bit rate; CYCLES_PER_BIT = CLK_HZ/BIT_RATE (128 at defaults, must be >= 8)
DEPTH, 4, FIFO entries; power of two, 2..16

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
uart_rxd  in  1  serial input, idle high, asynchronous to clk
uart_rts  out  1  flow control; 1 = stop sending
rx_read  in  1  pop strobe, one cycle per byte
rx_valid  out  1  FIFO not empty
rx_data  out  8  byte at FIFO head
rx_overrun  out  1  sticky: byte dropped because FIFO full
rx_frame_err  out  1  sticky: stop bit sampled low
clr_err  in  1  clears both sticky flags

Behaviour:
- Reset values (asynchronous on rst): FIFO empty, rx_valid=0, rx_data=0, rx_overrun=0, rx_frame_err=0, uart_rts=1, FSM IDLE.
  - Synchronizer flops reset to 1.
- uart_rxd passes through a 2-flop synchronizer. All FSM decisions use the synchronized value.
- Bit counter width is ceil(log2(CYCLES_PER_BIT)).
- FSM states:
  - IDLE:
    - On synchronized rxd==0, load timer with CYCLES_PER_BIT/2-1 and go to START.
  - START:
    - When timer expires, resample.
    - If rxd==0: load CYCLES_PER_BIT-1, bit index 0, go to DATA.
    - If rxd==1: glitch; return to IDLE, no flags.
  - DATA:
    - Sample at each timer expiry, LSB first into shift register.
    - After 8th sample go to STOP, or to PARITY when the optional feature is enabled.
  - STOP:
    - At expiry, sample rxd.
    - If 1: push byte.
    - If 0: set rx_frame_err and discard the byte.
    - Always return to IDLE the same cycle, so a start bit immediately following the stop bit is caught.
- Push when FIFO full and no pop this cycle: byte dropped, rx_overrun set; FIFO contents unchanged.
- Simultaneous push and pop:
  - When full: pop then push, no overrun, count unchanged.
  - When empty: push only.
- rx_read while empty: ignored, no pointer movement.
- rx_data and rx_valid are registered.
  - A pushed byte is visible with rx_valid=1 the cycle after the stop-bit sample.
  - After a pop, the next head byte appears the following cycle.
- Sticky flags:
  - clr_err clears both flags.
  - If clr_err coincides with a new error event, the set wins.
- uart_rts:
  - Registered; 1 when count >= DEPTH-1, else 0.
  - Updates one cycle after the count changes.
- A mid-frame rst aborts reception with no push. After release the FSM waits for a fresh falling edge.
- Pointers wrap modulo DEPTH. count has width log2(DEPTH)+1.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - After the 8 data bits, FSM enters PARITY and samples one even-parity bit.
  - On mismatch, the byte is discarded at STOP and output rx_parity_err (1 bit, sticky, cleared by clr_err, reset 0) is set.
  - Stop-bit check proceeds normally.
  - Frame is 11 bits.
- Undefined: no PARITY state, no rx_parity_err port, 10-bit frames.

Test Plan:
1. Reset then send 0xA5 at 128 cycles/bit -> rx_valid=1 one cycle after stop sample, rx_data=0xA5; pulse rx_read -> rx_valid=0 next cycle.
2. Send 0x01,0x02,0x03 back-to-back, no reads -> uart_rts rises after 3rd byte; read three times -> 0x01,0x02,0x03 in order; uart_rts=0 after first read.
3. Send 5 bytes with DEPTH=4 and no reads -> rx_overrun=1, FIFO holds first 4; pulse clr_err -> rx_overrun=0.
4. Send 0x55 with stop bit driven low -> rx_frame_err=1, rx_valid stays 0; 40-cycle low glitch on idle line -> no state change, no flags.
5. Fill FIFO, then pulse rx_read on the same cycle as the 5th byte's stop sample -> no overrun; head advances, 5th byte stored last.
6. Assert rst mid-byte (bit 4) -> all outputs return to reset values immediately; next full byte 0x3C received correctly.
